// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: bundle of requester-side job signals and pixel-side
// write signals for vga_plot_arbiter.
//   req/req_x/req_y/req_w/req_h/req_colour : packed per-requester job fields
//   ack/done                                : one-hot per-requester pulses
//   busy                                    : arbiter drawing or finishing
//   x/y/colour/plot                         : pixel write to the VGA adapter
// slave modport is the arbiter's view, master modport the requesters'/sink view.
interface vga_plot_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_x;
    logic [7*NUM_REQ-1:0] req_y;
    logic [4*NUM_REQ-1:0] req_w;
    logic [4*NUM_REQ-1:0] req_h;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [7:0]           x;
    logic [6:0]           y;
    logic [2:0]           colour;
    logic                 plot;

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_colour,
        output ack, done, busy, x, y, colour, plot
    );

    modport master (
        output req, req_x, req_y, req_w, req_h, req_colour,
        input  ack, done, busy, x, y, colour, plot
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin arbiter that rasterises solid-colour rectangle
// jobs into one pixel write per clock for the VGA adapter.
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : vga_plot_arbiter_if slave modport (job requests in, pixels out)
// Optional feature macro: PLOT_ARB_CLIP_EN -- when defined, pixels whose
// unwrapped x sum >= 160 or y sum >= 120 are issued with plot = 0; otherwise
// coordinates wrap modulo 256/128 and every pixel is plotted.
module vga_plot_arbiter #(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               reset,
    vga_plot_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [3:0]         cx_q, cx_d, cy_q, cy_d;
    logic [3:0]         lw_q, lw_d, lh_q, lh_d;
    logic [7:0]         lx_q, lx_d;
    logic [6:0]         ly_q, ly_d;
    logic [2:0]         lcol_q, lcol_d;
    logic [NUM_REQ-1:0] ack_q, ack_d, done_q, done_d;
    logic               busy_q, busy_d, plot_q, plot_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic [2:0]         col_q, col_d;

    // Round-robin search: first set req bit at or above ptr, wrapping.
    logic          found;
    logic [PW-1:0] pick, cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Pixel generator operands, selected by the FSM below.
    logic       pix_en;
    logic [7:0] bx;
    logic [6:0] by;
    logic [3:0] pcx, pcy;
    logic [8:0] xsum;
    logic [7:0] ysum;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        lw_d    = lw_q;
        lh_d    = lh_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        lcol_d  = lcol_q;
        ack_d   = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        plot_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        pix_en  = 1'b0;
        bx      = lx_q;
        by      = ly_q;
        pcx     = cx_q;
        pcy     = cy_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d  = pick;
                    lx_d   = bus.req_x[8*int'(pick) +: 8];
                    ly_d   = bus.req_y[7*int'(pick) +: 7];
                    lw_d   = bus.req_w[4*int'(pick) +: 4];
                    lh_d   = bus.req_h[4*int'(pick) +: 4];
                    lcol_d = bus.req_colour[3*int'(pick) +: 3];
                    ack_d  = NUM_REQ'(1) << pick;
                    ptr_d  = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    cx_d   = '0;
                    cy_d   = '0;
                    // First pixel comes straight from the request fields so it
                    // is presented in the same cycle as ack.
                    bx     = lx_d;
                    by     = ly_d;
                    pcx    = '0;
                    pcy    = '0;
                    col_d  = lcol_d;
                    pix_en = 1'b1;
                    busy_d = 1'b1;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                busy_d = 1'b1;
                if (cx_q == lw_q && cy_q == lh_q) begin
                    done_d  = NUM_REQ'(1) << win_q;
                    state_d = DONE;
                end else begin
                    if (cx_q == lw_q) begin
                        cx_d = '0;
                        cy_d = cy_q + 4'd1;
                    end else begin
                        cx_d = cx_q + 4'd1;
                    end
                    pcx    = cx_d;
                    pcy    = cy_d;
                    pix_en = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        xsum = {1'b0, bx} + {5'b0, pcx};
        ysum = {1'b0, by} + {4'b0, pcy};
        if (pix_en) begin
            x_d = xsum[7:0];
            y_d = ysum[6:0];
`ifdef PLOT_ARB_CLIP_EN
            plot_d = (xsum < 9'd160) && (ysum < 8'd120);
`else
            plot_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            lw_q    <= '0;
            lh_q    <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            lcol_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            lw_q    <= lw_d;
            lh_q    <= lh_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            lcol_q  <= lcol_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.plot   = plot_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = col_q;
endmodule
